lockstep_mode_ctrl: RTL

Sequences safe entry to and exit from lockstep mode for the 8 core-side TCDM ports of the cluster lockstep unit.
- On a configuration request, blocks new core requests and drains every in-flight transaction (granted but not yet r_valid).
- Only then flips lockstep_mode_o, releases the block and acknowledges.
- A drain timeout aborts the switch and flags a sticky error.

---
 rtl/lockstep_mode_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/lockstep_mode_ctrl.sv
// lockstep_mode_ctrl: sequences safe entry/exit of lockstep mode by blocking and draining core TCDM traffic
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cfg_req_i, cfg_mode_i         level mode-change request and requested mode (1 = lockstep)
//   cfg_ack_o                     one-cycle completion pulse (switch or abort)
//   cfg_clr_err_i                 clears the sticky timeout flag
//   core_req_i/gnt_i/rvalid_i     per-port TCDM handshake observed for outstanding tracking
//   req_block_o                   masks all core requests while switching
//   lockstep_mode_o               mode select for the lockstep unit
//   busy_o                        sequencer not idle
//   err_timeout_o                 sticky drain-timeout flag
//   drain_cycles_o                BLOCK+DRAIN cycles of the last completed switch (LOCKSTEP_CTRL_PERF_EN), else 0
module lockstep_mode_ctrl #(
  parameter int NB_CORES        = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_req_i,
  input  logic                cfg_mode_i,
  output logic                cfg_ack_o,
  input  logic                cfg_clr_err_i,
  input  logic [NB_CORES-1:0] core_req_i,
  input  logic [NB_CORES-1:0] core_gnt_i,
  input  logic [NB_CORES-1:0] core_rvalid_i,
  output logic                req_block_o,
  output logic                lockstep_mode_o,
  output logic                busy_o,
  output logic                err_timeout_o,
  output logic [15:0]         drain_cycles_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, BLOCK, DRAIN, SWITCH, ABORT, ACK} state_e;
  state_e state_q, state_d;
  logic [NB_CORES-1:0] pending;
  logic [TW-1:0] tcnt_q;
  logic tgt_q, all_idle, timeout;
  genvar i;
  generate
    for (i = 0; i < NB_CORES; i++) begin : g_cnt
      logic [CW-1:0] cnt_q;
      logic inc, dec;
      assign inc = core_req_i[i] & core_gnt_i[i];
      assign dec = core_rvalid_i[i];
      assign pending[i] = |cnt_q;
      always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else if (inc && !dec && cnt_q != CW'(MAX_OUTSTANDING)) cnt_q <= cnt_q + 1'b1;
        else if (dec && !inc && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  endgenerate
  // a grant in the current cycle still creates an in-flight transaction
  assign all_idle = ~|pending && ~|(core_req_i & core_gnt_i);
  assign timeout = tcnt_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (cfg_req_i) state_d = (cfg_mode_i == lockstep_mode_o) ? ACK : BLOCK;
      BLOCK:         state_d = DRAIN;
      DRAIN:         state_d = all_idle ? SWITCH : timeout ? ABORT : DRAIN;
      SWITCH, ABORT: state_d = ACK;
      default:       state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_o      = state_q != IDLE;
    cfg_ack_o   = state_q == ACK;
    req_block_o = busy_o && !cfg_ack_o;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tgt_q           <= 1'b0;
      tcnt_q          <= '0;
      lockstep_mode_o <= 1'b0;
      err_timeout_o   <= 1'b0;
    end else begin
      if (state_q == IDLE && cfg_req_i) tgt_q <= cfg_mode_i;
      tcnt_q          <= state_q == BLOCK ? '0 : state_q == DRAIN ? tcnt_q + 1'b1 : tcnt_q;
      lockstep_mode_o <= state_q == SWITCH ? tgt_q : lockstep_mode_o;
      err_timeout_o   <= state_q == ABORT ? 1'b1 : cfg_clr_err_i ? 1'b0 : err_timeout_o;
    end
`ifdef LOCKSTEP_CTRL_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      perf_q         <= '0;
      drain_cycles_o <= '0;
    end else begin
      perf_q         <= (state_q == BLOCK || state_q == DRAIN) ? perf_q + {15'd0, perf_q != 16'hFFFF} :
                        state_q == IDLE ? '0 : perf_q;
      drain_cycles_o <= (state_q == SWITCH || state_q == ABORT) ? perf_q : drain_cycles_o;
    end
`else
  assign drain_cycles_o = '0;
`endif
endmodule
